muldiv_unit: RTL and testbench

//  Iterative 64-bit multiply/divide unit between the register file read ports and its write port.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_UDIV  = 2'b10;
  localparam logic [1:0] OP_SDIV  = 2'b11;

  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
module muldiv_step #(
  parameter int WIDTH = 64
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opr_i,
  input  logic [WIDTH-1:0]     mcand_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic [WIDTH-1:0]     opr_o
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;

  // Multiply adds into the upper half and shifts right; divide shifts the
  // next dividend bit into the remainder and keeps the difference when it fits.
  always_comb begin
    addend = opr_i[0] ? mcand_i : {WIDTH{1'b0}};
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    rem_sh = {acc_i[WIDTH-1:0], opr_i[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, mcand_i};
    if (is_div) begin
      if (diff[WIDTH+1]) begin
        acc_o = {{(WIDTH-1){1'b0}}, rem_sh};
        opr_o = {opr_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_o = {{(WIDTH-1){1'b0}}, diff[WIDTH:0]};
        opr_o = {opr_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
      opr_o = {1'b0, opr_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit feeding the register file write port.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic [TAG_W-1:0] RdIn,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [TAG_W-1:0] RdOut,
  output logic             RegWr
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               regwr_q, regwr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [TAG_W-1:0]   rd_q, rd_d;
  logic               neg_q, neg_d;
  logic               div0_q, div0_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opr_q, opr_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               is_div;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0]   opr_nx;
  logic [WIDTH-1:0]   final_res;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] abs2c(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? neg2c(v) : v;
  endfunction

  assign is_div = (op_q == OP_UDIV) || (op_q == OP_SDIV);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc_i   (acc_q),
    .opr_i   (opr_q),
    .mcand_i (mcand_q),
    .acc_o   (acc_nx),
    .opr_o   (opr_nx)
  );

  // Select the finished value from the last iteration's outputs, with sign fixup.
  always_comb begin
    final_res = '0;
    case (op_q)
      OP_MUL:   final_res = acc_nx[WIDTH-1:0];
      OP_UMULH: final_res = acc_nx[2*WIDTH-1:WIDTH];
      OP_UDIV:  final_res = div0_q ? '0 : opr_nx;
      default:  final_res = div0_q ? '0 : (neg_q ? neg2c(opr_nx) : opr_nx);
    endcase
  end

  // Sequencing: accept in IDLE, WIDTH steps in CALC, one result cycle in DONE.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    regwr_d  = 1'b0;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    acc_d    = acc_q;
    opr_d    = opr_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (Start && !Flush) begin
          state_d = S_CALC;
          busy_d  = 1'b1;
          cnt_d   = '0;
          op_d    = Op;
          rd_d    = RdIn;
          acc_d   = '0;
          div0_d  = (OpB == '0);
          neg_d   = 1'b0;
          case (Op)
            OP_UDIV: begin
              opr_d   = OpA;
              mcand_d = OpB;
            end
            OP_SDIV: begin
              opr_d   = abs2c(OpA);
              mcand_d = abs2c(OpB);
              neg_d   = OpA[WIDTH-1] ^ OpB[WIDTH-1];
            end
            default: begin
              opr_d   = OpB;
              mcand_d = OpA;
            end
          endcase
        end
      end
      S_CALC: begin
        if (Flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          acc_d = acc_nx;
          opr_d = opr_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            done_d   = 1'b1;
            regwr_d  = (rd_q != TAG_W'(ZERO_REG));
            result_d = final_res;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; asynchronous reset clears everything including datapath.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      regwr_q  <= 1'b0;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      acc_q    <= '0;
      opr_q    <= '0;
      mcand_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      regwr_q  <= regwr_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      acc_q    <= acc_d;
      opr_q    <= opr_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign RegWr  = regwr_q;
  assign Result = result_q;
  assign RdOut  = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with hand-computed expected results.
module tb_muldiv_unit;

  localparam int WIDTH = 64;
  localparam int TAG_W = 5;

  logic             Clk;
  logic             Reset_n;
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic [TAG_W-1:0] RdIn;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic [TAG_W-1:0] RdOut;
  logic             RegWr;

  int checks = 0;
  int errors = 0;
  int dn;

  muldiv_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .Op      (Op),
    .OpA     (OpA),
    .OpB     (OpB),
    .RdIn    (RdIn),
    .Flush   (Flush),
    .Busy    (Busy),
    .Done    (Done),
    .Result  (Result),
    .RdOut   (RdOut),
    .RegWr   (RegWr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Present an op for one accept edge (E0); returns just after E0.
  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd);
    @(negedge Clk);
    Start = 1'b1;
    Op    = op;
    OpA   = a;
    OpB   = b;
    RdIn  = rd;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  // Wait n edges, counting Done pulses sampled 1ns after each edge.
  task automatic wait_edges(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1 if (Done) dones++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp, input logic exp_wr);
    int d;
    issue(op, a, b, rd);
    wait_edges(WIDTH - 1, d);
    check({tag, "_early_done"}, 64'(d), 64'd0);
    @(posedge Clk);
    #1;
    check({tag, "_done"},   {63'd0, Done},  64'd1);
    check({tag, "_result"}, Result,         exp);
    check({tag, "_rd"},     {59'd0, RdOut}, {59'd0, rd});
    check({tag, "_regwr"},  {63'd0, RegWr}, {63'd0, exp_wr});
    @(posedge Clk);
    #1;
    check({tag, "_done_off"}, {63'd0, Done},  64'd0);
    check({tag, "_wr_off"},   {63'd0, RegWr}, 64'd0);
    check({tag, "_busy_off"}, {63'd0, Busy},  64'd0);
  endtask

  initial begin
    Reset_n = 1'b0;
    Start   = 1'b0;
    Op      = 2'b00;
    OpA     = '0;
    OpB     = '0;
    RdIn    = '0;
    Flush   = 1'b0;

    repeat (2) @(posedge Clk);
    #1;
    check("rst_busy",   {63'd0, Busy},  64'd0);
    check("rst_done",   {63'd0, Done},  64'd0);
    check("rst_regwr",  {63'd0, RegWr}, 64'd0);
    check("rst_result", Result,         64'd0);
    check("rst_rd",     {59'd0, RdOut}, 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    run_op("mul_7x6", 2'b00, 64'd7, 64'd6, 5'd9, 64'd42, 1'b1);
    run_op("umulh_max_x2", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'd1, 1'b1);
    run_op("mul_max_x2", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    run_op("udiv_100_7", 2'b10, 64'd100, 64'd7, 5'd1, 64'd14, 1'b1);
    run_op("udiv_5_0", 2'b10, 64'd5, 64'd0, 5'd2, 64'd0, 1'b1);
    run_op("sdiv_m100_7", 2'b11, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd10,
           64'hFFFF_FFFF_FFFF_FFF2, 1'b1);
    run_op("sdiv_min_m1", 2'b11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11,
           64'h8000_0000_0000_0000, 1'b1);
    run_op("sdiv_m9_m3", 2'b11, 64'hFFFF_FFFF_FFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd12,
           64'd3, 1'b1);

    // Start during a running op must be ignored.
    issue(2'b00, 64'd5, 64'd5, 5'd4);
    wait_edges(9, dn);
    check("busy_start_early", 64'(dn), 64'd0);
    @(negedge Clk);
    Start = 1'b1;
    Op    = 2'b00;
    OpA   = 64'd2;
    OpB   = 64'd2;
    RdIn  = 5'd8;
    @(posedge Clk);
    #1 Start = 1'b0;
    wait_edges(53, dn);
    check("busy_start_mid", 64'(dn), 64'd0);
    @(posedge Clk);
    #1;
    check("busy_start_done",   {63'd0, Done},  64'd1);
    check("busy_start_result", Result,         64'd25);
    check("busy_start_rd",     {59'd0, RdOut}, 64'd4);
    wait_edges(80, dn);
    check("busy_start_no_second", 64'(dn), 64'd0);

    run_op("udiv_rd31", 2'b10, 64'd100, 64'd10, 5'd31, 64'd10, 1'b0);

    // Flush at edge 20 of an op.
    issue(2'b00, 64'd3, 64'd4, 5'd5);
    wait_edges(19, dn);
    @(negedge Clk);
    Flush = 1'b1;
    @(posedge Clk);
    #1 Flush = 1'b0;
    check("flush_busy", {63'd0, Busy}, 64'd0);
    check("flush_done", {63'd0, Done}, 64'd0);
    wait_edges(60, dn);
    check("flush_no_done", 64'(dn), 64'd0);
    check("flush_result_hold", Result, 64'd10);

    // Asynchronous reset at edge 30 of an op.
    issue(2'b00, 64'd3, 64'd5, 5'd6);
    wait_edges(30, dn);
    Reset_n = 1'b0;
    #1;
    check("arst_busy",   {63'd0, Busy},  64'd0);
    check("arst_done",   {63'd0, Done},  64'd0);
    check("arst_regwr",  {63'd0, RegWr}, 64'd0);
    check("arst_result", Result,         64'd0);
    check("arst_rd",     {59'd0, RdOut}, 64'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    wait_edges(70, dn);
    check("arst_no_done", 64'(dn), 64'd0);

    run_op("mul_3x3", 2'b00, 64'd3, 64'd3, 5'd7, 64'd9, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
